// File: rtl/dma_write_master_if.sv
`default_nettype none
// ============================================================================
// Module   : dma_write_master_if
// Brief    : AXI4 write-channel bundle (AW/W/B) between a write master and a slave.
// Revision : 1.0 - initial release
// ============================================================================
interface dma_write_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface
`default_nettype wire

// File: rtl/dma_write_master.sv
`default_nettype none
// ============================================================================
// Module   : dma_write_master
// Brief    : Drains FIFO words into memory as AXI4 INCR bursts, one burst in flight.
// Options  : DMA_WR_BRESP_ERR_EN adds o_write_err and aborts on an error response.
// Revision : 1.0 - initial release
// ============================================================================
module dma_write_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int MAX_BURST_BYTES    = 256
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_dst_addr,
    input  logic [31:0]                   i_total_len,
    output logic                          o_write_done,
    input  logic                          i_fifo_empty,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] i_fifo_data,
    output logic                          o_fifo_pop,
`ifdef DMA_WR_BRESP_ERR_EN
    output logic                          o_write_err,
`endif
    dma_write_master_if.master            m_axi
);

    localparam logic [31:0] c_max_burst = 32'(MAX_BURST_BYTES);
    localparam logic [31:0] c_page      = 32'h0000_1000;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_ADDR = 4'b0010,
        S_DATA = 4'b0100,
        S_RESP = 4'b1000
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rem_q, rem_d;
    logic        awvalid_q, awvalid_d;
    logic [7:0]  last_idx_q, last_idx_d;
    logic [7:0]  beat_q, beat_d;
    logic        done_q, done_d;
`ifdef DMA_WR_BRESP_ERR_EN
    logic        err_q, err_d;
`endif

    logic [31:0] w_start_addr;
    logic [31:0] w_start_len;
    logic [31:0] w_to_page;
    logic [31:0] w_burst;
    logic [7:0]  w_awlen;
    logic        w_wvalid;
    logic        w_wlast;
    logic        w_w_hs;
    logic        w_unused;

    assign w_start_addr = {i_dst_addr[31:2], 2'b00};
    assign w_start_len  = {i_total_len[31:2], 2'b00};

    // Burst length depends only on registered address/remaining, so AW stays stable while pending.
    assign w_to_page = c_page - {20'd0, addr_q[11:0]};

    always_comb begin
        w_burst = rem_q;
        if (w_burst > c_max_burst) begin
            w_burst = c_max_burst;
        end
        if (w_burst > w_to_page) begin
            w_burst = w_to_page;
        end
    end

    // A 1024-byte burst gives [9:2] == 0, which wraps to awlen 255 as intended.
    assign w_awlen = w_burst[9:2] - 8'd1;

    assign w_wvalid = (state_q == S_DATA) && !i_fifo_empty;
    assign w_wlast  = w_wvalid && (beat_q == last_idx_q);
    assign w_w_hs   = w_wvalid && m_axi.wready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= 32'd0;
            rem_q      <= 32'd0;
            awvalid_q  <= 1'b0;
            last_idx_q <= 8'd0;
            beat_q     <= 8'd0;
            done_q     <= 1'b0;
`ifdef DMA_WR_BRESP_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            awvalid_q  <= awvalid_d;
            last_idx_q <= last_idx_d;
            beat_q     <= beat_d;
            done_q     <= done_d;
`ifdef DMA_WR_BRESP_ERR_EN
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        awvalid_d  = awvalid_q;
        last_idx_d = last_idx_q;
        beat_d     = beat_q;
        done_d     = done_q;
`ifdef DMA_WR_BRESP_ERR_EN
        err_d      = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
`ifdef DMA_WR_BRESP_ERR_EN
                    err_d = 1'b0;
`endif
                    if (w_start_len == 32'd0) begin
                        done_d = 1'b1;
                    end else begin
                        done_d    = 1'b0;
                        addr_d    = w_start_addr;
                        rem_d     = w_start_len;
                        awvalid_d = 1'b1;
                        state_d   = S_ADDR;
                    end
                end
            end

            S_ADDR: begin
                if (awvalid_q && m_axi.awready) begin
                    awvalid_d  = 1'b0;
                    last_idx_d = w_awlen;
                    beat_d     = 8'd0;
                    state_d    = S_DATA;
                end
            end

            S_DATA: begin
                if (w_w_hs) begin
                    beat_d = beat_q + 8'd1;
                    if (w_wlast) begin
                        state_d = S_RESP;
                    end
                end
            end

            S_RESP: begin
                if (m_axi.bvalid) begin
                    addr_d = addr_q + w_burst;
                    rem_d  = rem_q - w_burst;
`ifdef DMA_WR_BRESP_ERR_EN
                    if (m_axi.bresp != 2'b00) begin
                        err_d = 1'b1;
                        rem_d = 32'd0;
                    end
`endif
                    // Raise AW for the next burst in the same edge as B to save a cycle.
                    if (rem_d != 32'd0) begin
                        awvalid_d = 1'b1;
                        state_d   = S_ADDR;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                awvalid_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = w_awlen;
    assign m_axi.awsize  = 3'b010;
    assign m_axi.awburst = 2'b01;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = i_fifo_data;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.wlast   = w_wlast;
    assign m_axi.wvalid  = w_wvalid;
    assign m_axi.bready  = (state_q == S_RESP);

    assign o_fifo_pop   = w_w_hs;
    assign o_write_done = done_q;
`ifdef DMA_WR_BRESP_ERR_EN
    assign o_write_err  = err_q;
    assign w_unused     = &{1'b0, i_dst_addr[1:0], i_total_len[1:0]};
`else
    assign w_unused     = &{1'b0, i_dst_addr[1:0], i_total_len[1:0], m_axi.bresp};
`endif

endmodule
`default_nettype wire

// File: doc/dma_write_master.md
Name: dma_write_master

Overview:
AXI4-Full write-master engine for the DMA datapath. It drains 32-bit words from the transfer FIFO and writes them to memory as INCR bursts over AW/W/B. Bursts are limited to MAX_BURST_BYTES and never cross a 4 KB boundary. It is the write-side counterpart of the DMA read engine, which fills the same FIFO.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, AXI address width; must be 32.
C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
MAX_BURST_BYTES, 256, per-burst byte limit; power of two, 4 to 1024.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
i_start  in  1  start pulse; sampled only in IDLE
i_dst_addr  in  32  destination byte address; bits [1:0] treated as 0
i_total_len  in  32  byte count; bits [1:0] treated as 0
o_write_done  out  1  sticky completion flag; cleared by the next accepted i_start
i_fifo_empty  in  1  FIFO empty flag
i_fifo_data  in  32  FIFO head word (first-word-fall-through)
o_fifo_pop  out  1  FIFO pop strobe
m_axi_awaddr  out  32  burst start address
m_axi_awlen  out  8  beats-1
m_axi_awsize  out  3  constant 3'b010
m_axi_awburst  out  2  constant 2'b01 (INCR)
m_axi_awvalid  out  1  registered
m_axi_awready  in  1
m_axi_wdata  out  32  = i_fifo_data
m_axi_wstrb  out  4  constant 4'hF
m_axi_wlast  out  1  last-beat flag
m_axi_wvalid  out  1
m_axi_wready  in  1
m_axi_bresp  in  2
m_axi_bvalid  in  1
m_axi_bready  out  1

Behaviour:
- Reset values: all registers 0; state IDLE; awvalid=0; o_write_done=0. wvalid, bready and pop are 0 because they decode from the state.
- States are one-hot: IDLE, ADDR, DATA, RESP.
- IDLE:
  - i_start with aligned length = 0: o_write_done is set next cycle; state stays IDLE; no AW is issued.
  - i_start with length > 0: latch addr and length, clear done, set awvalid, go to ADDR. awvalid is high on the first ADDR cycle.
- Burst size: burst_bytes = min(remaining, MAX_BURST_BYTES, 0x1000 - addr[11:0]).
  - awlen = (burst_bytes>>2) - 1.
  - Computed combinationally from the registered addr and remaining, so it is stable while awvalid is high.
- ADDR:
  - awvalid is held until awready is seen.
  - On the handshake: awvalid clears, beat count is latched, beat counter resets to 0, go to DATA.
  - awaddr and awlen must not change while awvalid=1.
- DATA:
  - wvalid = !i_fifo_empty.
  - o_fifo_pop = wvalid & wready, so pop is never asserted when the FIFO is empty.
  - wlast = (beat counter == beats-1), qualified with wvalid.
  - The counter increments on each W handshake.
  - Handshake on the last beat: go to RESP.
  - Empty gaps and wready backpressure are both legal; word order must be preserved.
- RESP:
  - bready = 1.
  - On bvalid: addr += burst_bytes and remaining -= burst_bytes.
  - If remaining is then nonzero: set awvalid (look-ahead) and go to ADDR.
  - Otherwise set o_write_done and go to IDLE.
- Only one burst is outstanding at a time; AW for burst N+1 is never issued before B of burst N.
- i_start outside IDLE is ignored.
- Reset asserted mid-operation returns the block to IDLE immediately.
  - Partially written bursts are abandoned.
  - FIFO flushing is the system's responsibility.
- Address arithmetic wraps modulo 2^32 with no overflow flag.

Optional Feature:
Macro DMA_WR_BRESP_ERR_EN.
- Defined:
  - Adds output o_write_err (1 bit). It resets to 0 and is cleared on an accepted i_start.
  - A bvalid with bresp != 2'b00 sets o_write_err, forces remaining to 0, and takes the done/IDLE path. No further AW is issued.
- Undefined:
  - Port o_write_err is absent and bresp is ignored.
  - Every transfer runs to full length.

Test Plan:
1. start, dst=0x1000, len=64, FIFO always full-ready, awready/wready/bvalid immediate → one AW: addr 0x1000, awlen 15; 16 W beats with wlast on beat 16; done=1 after B.
2. dst=0x0, len=1024 → four AWs at 0x000/0x100/0x200/0x300, each awlen 63; 256 pops total; done after the 4th B.
3. dst=0x0FF0, len=64 → AW 0xFF0 awlen 3, then AW 0x1000 awlen 11; no burst crosses 4 KB.
4. FIFO empty every 3rd cycle and wready random 50% → wvalid=0 while empty, pop only on handshake, wdata sequence matches the FIFO, exactly awlen+1 beats per burst.
5. awready delayed 5 cycles, and len=0 start → awvalid held with awaddr/awlen stable; the len=0 start gives done=1 with no AW.
6. Macro defined: len=512 at 0x0, first bresp=2'b10 → o_write_err=1, done=1, no second AW. Reset asserted mid-DATA returns all outputs to reset values.
